// File: rtl/online_mult_operand_gen.sv
// online_mult_operand_gen
//   Operand feeder for a radix-2 online multiplier slice. It takes one
//   signed digit of X and one of Y per iteration and keeps the on-the-fly
//   appended operands X[j] and Y[j-1]. It registers the selected multiples
//   and their negation carries behind a valid/ready handshake, then appends
//   ONLINE_DELAY flush iterations.
//
//   Optional build macro: ONLINE_MULT_OPGEN_DIGIT_CHECK_EN adds the sticky
//   err_digit output, which flags an accepted digit encoded as 11.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   start               begin a new multiplication (honoured in IDLE only)
//   in_valid/in_ready   digit pair handshake
//   x_digit, y_digit    signed digits {plus,minus}: 10=+1, 01=-1, 00/11=0
//   out_valid/out_ready output register handshake
//   x_sel, y_sel        Y[j-1]*x_j and X[j]*y_j (ones-complemented for -1)
//   cin1, cin2          negation carries for x_sel / y_sel
//   z_emit              iteration index >= ONLINE_DELAY
//   last                final iteration of the operation
//   busy                FSM not in IDLE
//
// State | meaning
//   IDLE  | waiting for start; X/Y hold the previous operands
//   RUN   | accepting digit pairs 1..N
//   FLUSH | emitting ONLINE_DELAY zero iterations
module online_mult_operand_gen #(
  parameter int FULL_WIDTH   = 21,
  parameter int PRECISION    = 16,
  parameter int ONLINE_DELAY = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [1:0]            x_digit,
  input  logic [1:0]            y_digit,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [FULL_WIDTH-1:0] x_sel,
  output logic [FULL_WIDTH-1:0] y_sel,
  output logic                  cin1,
  output logic                  cin2,
  output logic                  z_emit,
  output logic                  last,
  output logic                  busy
`ifdef ONLINE_MULT_OPGEN_DIGIT_CHECK_EN
  ,
  output logic                  err_digit
`endif
);

  localparam int F     = FULL_WIDTH - 2;
  localparam int TOTAL = PRECISION + ONLINE_DELAY;
  localparam int CW    = $clog2(TOTAL + 1);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

  state_t                state, state_nxt;
  logic [FULL_WIDTH-1:0] x_acc, y_acc, x_acc_nxt, y_acc_nxt;
  logic [CW-1:0]         cnt, cnt_nxt;
  logic                  load;
  logic [FULL_WIDTH-1:0] x_sel_nxt, y_sel_nxt;
  logic                  cin1_nxt, cin2_nxt;
  logic                  reg_free, accept;
  logic                  x_pos, x_neg, y_pos, y_neg;
  logic [FULL_WIDTH-1:0] weight;

  // 11 is neither +1 nor -1, so it falls through as a zero digit.
  assign x_pos = (x_digit == 2'b10);
  assign x_neg = (x_digit == 2'b01);
  assign y_pos = (y_digit == 2'b10);
  assign y_neg = (y_digit == 2'b01);

  assign reg_free = !out_valid || out_ready;
  assign in_ready = (state == RUN) && reg_free;
  assign accept   = in_ready && in_valid;
  assign busy     = (state != IDLE);

  // Digit j = cnt+1 carries weight 2^-j, i.e. bit F-j. Only used in RUN,
  // where cnt < PRECISION <= F keeps the shift in range.
  assign weight = FULL_WIDTH'(1) << (F - 1 - int'(cnt));

  always_comb begin
    state_nxt = state;
    x_acc_nxt = x_acc;
    y_acc_nxt = y_acc;
    cnt_nxt   = cnt;
    load      = 1'b0;
    x_sel_nxt = '0;
    y_sel_nxt = '0;
    cin1_nxt  = 1'b0;
    cin2_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = RUN;
          x_acc_nxt = '0;
          y_acc_nxt = '0;
          cnt_nxt   = '0;
        end
      end
      RUN: begin
        if (accept) begin
          // X is appended first so y_sel sees X[j]; x_sel sees Y[j-1].
          x_acc_nxt = x_pos ? x_acc + weight : (x_neg ? x_acc - weight : x_acc);
          x_sel_nxt = x_pos ? y_acc : (x_neg ? ~y_acc : '0);
          y_sel_nxt = y_pos ? x_acc_nxt : (y_neg ? ~x_acc_nxt : '0);
          cin1_nxt  = x_neg;
          cin2_nxt  = y_neg;
          y_acc_nxt = y_pos ? y_acc + weight : (y_neg ? y_acc - weight : y_acc);
          load      = 1'b1;
          cnt_nxt   = cnt + CW'(1);
          if (cnt == CW'(PRECISION - 1)) state_nxt = FLUSH;
        end
      end
      FLUSH: begin
        if (reg_free) begin
          load    = 1'b1;
          cnt_nxt = cnt + CW'(1);
          if (cnt == CW'(TOTAL - 1)) state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      x_acc <= '0;
      y_acc <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      x_acc <= x_acc_nxt;
      y_acc <= y_acc_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Output register: reloads on push (also when popped in the same cycle),
  // otherwise holds every field until the consumer takes it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      x_sel     <= '0;
      y_sel     <= '0;
      cin1      <= 1'b0;
      cin2      <= 1'b0;
      z_emit    <= 1'b0;
      last      <= 1'b0;
    end else if (load) begin
      out_valid <= 1'b1;
      x_sel     <= x_sel_nxt;
      y_sel     <= y_sel_nxt;
      cin1      <= cin1_nxt;
      cin2      <= cin2_nxt;
      z_emit    <= (cnt >= CW'(ONLINE_DELAY));
      last      <= (cnt == CW'(TOTAL - 1));
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef ONLINE_MULT_OPGEN_DIGIT_CHECK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_digit <= 1'b0;
    end else if (state == IDLE && start) begin
      err_digit <= 1'b0;
    end else if (accept && (x_digit == 2'b11 || y_digit == 2'b11)) begin
      err_digit <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_online_mult_operand_gen.sv
module tb_online_mult_operand_gen;

  localparam int W = 21;
  localparam int F = W - 2;
  localparam int N = 16;
  localparam int D = 3;
  localparam longint MASK = (longint'(1) << W) - 1;

  logic clk = 1'b0;
  logic rst_n, start, in_valid, in_ready, out_valid, out_ready;
  logic [1:0] x_digit, y_digit;
  logic [W-1:0] x_sel, y_sel;
  logic cin1, cin2, z_emit, last, busy;
`ifdef ONLINE_MULT_OPGEN_DIGIT_CHECK_EN
  logic err_digit;
`endif

  always #5 clk = ~clk;

  online_mult_operand_gen #(.FULL_WIDTH(W), .PRECISION(N), .ONLINE_DELAY(D)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .x_digit(x_digit), .y_digit(y_digit), .out_valid(out_valid), .out_ready(out_ready),
    .x_sel(x_sel), .y_sel(y_sel), .cin1(cin1), .cin2(cin2), .z_emit(z_emit),
    .last(last), .busy(busy)
`ifdef ONLINE_MULT_OPGEN_DIGIT_CHECK_EN
    , .err_digit(err_digit)
`endif
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    longint xs, ys;
    bit c1, c2, z, l;
  } exp_t;

  exp_t   q[$];
  longint mx, my;
  int     m_idx;

  function automatic int dval(input logic [1:0] d);
    if (d == 2'b10) return 1;
    if (d == 2'b01) return -1;
    return 0;
  endfunction

  function automatic longint selm(input longint a, input int d);
    if (d == 1) return a;
    if (d == -1) return (~a) & MASK;
    return 0;
  endfunction

  task automatic model_push(input longint xs, input longint ys, input bit c1, input bit c2);
    exp_t e;
    e.xs = xs; e.ys = ys; e.c1 = c1; e.c2 = c2;
    e.z = (m_idx >= D);
    e.l = (m_idx == N + D - 1);
    q.push_back(e);
    m_idx++;
  endtask

  task automatic model_accept(input int j, input logic [1:0] xd, input logic [1:0] yd);
    int dx, dy;
    longint w, xs, ys;
    dx = dval(xd);
    dy = dval(yd);
    w  = longint'(1) << (F - j);
    mx = (mx + dx * w) & MASK;
    xs = selm(my, dx);
    ys = selm(mx, dy);
    my = (my + dy * w) & MASK;
    model_push(xs, ys, dx == -1, dy == -1);
    if (j == N) for (int k = 0; k < D; k++) model_push(0, 0, 0, 0);
  endtask

  // ---------------- table of hand-derived first iterations ----------------
  typedef struct {
    logic [1:0] xd, yd;
    logic [W-1:0] xs, ys;
    logic c1, c2, z;
  } vec_t;
  localparam int NT = 5;
  vec_t tbl [NT];

  // ---------------- scoreboard / monitor ----------------
  bit mon_en = 1'b0;
  bit tbl_active = 1'b0;
  int n_xfer = 0, z_cnt = 0, last_cnt = 0;

  always @(negedge clk) begin
    if (mon_en && out_valid) begin
      if (!out_ready) begin
        chk("in_ready_stall", in_ready, 0);
        if (q.size() > 0) begin
          chk("hold_x_sel", x_sel, q[0].xs);
          chk("hold_y_sel", y_sel, q[0].ys);
        end
      end else begin
        if (q.size() == 0) begin
          chk("unexpected_output", 1, 0);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("x_sel", x_sel, e.xs);
          chk("y_sel", y_sel, e.ys);
          chk("cin1", cin1, e.c1);
          chk("cin2", cin2, e.c2);
          chk("z_emit", z_emit, e.z);
          chk("last", last, e.l);
        end
        if (tbl_active && n_xfer < NT) begin
          chk("tbl_x_sel", x_sel, tbl[n_xfer].xs);
          chk("tbl_y_sel", y_sel, tbl[n_xfer].ys);
          chk("tbl_cin1", cin1, tbl[n_xfer].c1);
          chk("tbl_cin2", cin2, tbl[n_xfer].c2);
          chk("tbl_z_emit", z_emit, tbl[n_xfer].z);
        end
        n_xfer++;
        if (z_emit) z_cnt++;
        if (last) last_cnt++;
      end
    end
  end

  // ---------------- out_ready driver ----------------
  bit rand_ready = 1'b0;
  int stall_at = -1, stall_left = 0;

  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (stall_left > 0 && stall_at >= 0 && n_xfer >= stall_at) begin
        out_ready = 1'b0;
        stall_left--;
      end else if (rand_ready) begin
        out_ready = ($urandom_range(0, 3) != 0);
      end else begin
        out_ready = 1'b1;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  logic [1:0] xd [1:N];
  logic [1:0] yd [1:N];
  bit pulse_start = 1'b0;

  task automatic model_start();
    mx = 0; my = 0; m_idx = 0;
    q.delete();
    n_xfer = 0; z_cnt = 0; last_cnt = 0;
  endtask

  task automatic do_start();
    @(posedge clk); #1 start = 1'b1;
    @(negedge clk);
    model_start();
    @(posedge clk); #1 start = 1'b0;
    chk("busy_after_start", busy, 1);
  endtask

  task automatic feed(input int ndig);
    for (int j = 1; j <= ndig; j++) begin
      bit got;
      in_valid = 1'b1;
      x_digit  = xd[j];
      y_digit  = yd[j];
      if (pulse_start && j == 6) start = 1'b1;
      got = 1'b0;
      for (int c = 0; c < 200 && !got; c++) begin
        @(negedge clk);
        if (in_ready) got = 1'b1;
      end
      if (!got) begin
        chk("accept_timeout", 0, 1);
        in_valid = 1'b0;
        return;
      end
      model_accept(j, xd[j], yd[j]);
      @(posedge clk); #1;
      start = 1'b0;
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_done();
    bit done;
    done = 1'b0;
    for (int c = 0; c < 1000 && !done; c++) begin
      @(negedge clk);
      if (!busy && !out_valid) done = 1'b1;
    end
    chk("done_timeout", done, 1);
    chk("iterations", n_xfer, N + D);
    chk("z_emit_count", z_cnt, N);
    chk("last_count", last_cnt, 1);
    chk("queue_empty", q.size(), 0);
  endtask

  task automatic rand_digits();
    for (int j = 1; j <= N; j++) begin
      xd[j] = 2'($urandom_range(0, 3));
      yd[j] = 2'($urandom_range(0, 3));
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    tbl[0] = '{2'b10, 2'b10, 21'h000000, 21'h040000, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{2'b01, 2'b00, 21'h1BFFFF, 21'h000000, 1'b1, 1'b0, 1'b0};
    tbl[2] = '{2'b00, 2'b01, 21'h000000, 21'h1DFFFF, 1'b0, 1'b1, 1'b0};
    tbl[3] = '{2'b10, 2'b10, 21'h030000, 21'h028000, 1'b0, 1'b0, 1'b1};
    tbl[4] = '{2'b11, 2'b10, 21'h000000, 21'h028000, 1'b0, 1'b0, 1'b1};

    rst_n = 1'b0; start = 1'b1; in_valid = 1'b0; x_digit = 2'b00; y_digit = 2'b00;
    #3;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_x_sel", x_sel, 0);
    chk("rst_y_sel", y_sel, 0);
    chk("rst_cin", {cin1, cin2}, 0);
    chk("rst_z_last", {z_emit, last}, 0);
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", in_ready, 0);
    @(negedge clk);
    @(negedge clk);
    chk("rst_busy_held", busy, 0);
    rst_n = 1'b1;
    model_start();
    @(posedge clk); #1 start = 1'b0;
    chk("busy_first_edge", busy, 1);

    // op 1: table digits then random, out_ready held high
    rand_digits();
    for (int i = 0; i < NT; i++) begin
      xd[i+1] = tbl[i].xd;
      yd[i+1] = tbl[i].yd;
    end
    tbl_active = 1'b1;
    mon_en = 1'b1;
    feed(N);
    wait_done();
    tbl_active = 1'b0;
`ifdef ONLINE_MULT_OPGEN_DIGIT_CHECK_EN
    chk("err_digit_set", err_digit, 1);
`endif

    // op 2: 5-cycle consumer stall mid-RUN, plus ignored start mid-RUN
    rand_digits();
    do_start();
`ifdef ONLINE_MULT_OPGEN_DIGIT_CHECK_EN
    chk("err_digit_cleared", err_digit, 0);
`endif
    stall_at = 6; stall_left = 5; pulse_start = 1'b1;
    feed(N);
    wait_done();
    pulse_start = 1'b0; stall_at = -1;

    // ops 3..6: random digits with random back-pressure
    rand_ready = 1'b1;
    for (int op = 0; op < 4; op++) begin
      rand_digits();
      do_start();
      feed(N);
      wait_done();
    end
    rand_ready = 1'b0;

    // asynchronous reset at iteration 7, then a fresh operation
    rand_digits();
    do_start();
    feed(8);
    mon_en = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", out_valid, 0);
    chk("arst_sel", {x_sel, y_sel}, 0);
    chk("arst_flags", {cin1, cin2, z_emit, last}, 0);
    chk("arst_busy", busy, 0);
    chk("arst_in_ready", in_ready, 0);
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    mon_en = 1'b1;
    rand_digits();
    do_start();
    feed(N);
    wait_done();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
